// File: rtl/lightbike_engine.sv
// lightbike_engine: N-player lightbike game engine.
// Owns the play-field occupancy memory, steps every live bike once per game tick,
// applies latched turns, resolves wall/trail/head-on crashes and declares the result.
module lightbike_engine #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 16,
  parameter int NUM_PLAYERS = 2,
  parameter int TICK_CYCLES = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int AW = $clog2(GRID_W * GRID_H),
  localparam int OW = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Ack,
  input  logic [NUM_PLAYERS-1:0]    TurnL,
  input  logic [NUM_PLAYERS-1:0]    TurnR,
  input  logic [AW-1:0]             rd_addr,
  output logic [OW-1:0]             rd_data,
  output logic [NUM_PLAYERS-1:0]    alive,
  output logic [NUM_PLAYERS*XW-1:0] head_x,
  output logic [NUM_PLAYERS*YW-1:0] head_y,
  output logic [1:0]                winner,
  output logic                      draw,
  output logic [8:0]                state
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int PIW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [XW:0]     X_LIMIT   = (XW + 1)'(GRID_W);
  localparam logic [YW:0]     Y_LIMIT   = (YW + 1)'(GRID_H);
  localparam logic [YW-1:0]   START_Y   = YW'(GRID_H / 2);
  localparam logic [PIW-1:0]  LAST_P    = PIW'(NUM_PLAYERS - 1);
  localparam logic [TW-1:0]   LAST_TICK = TW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0]   LAST_CELL = AW'(CELLS - 1);

  // One-hot encoding so the state register can be exported directly
  typedef enum logic [8:0] {
    ST_IDLE  = 9'h001,
    ST_CLEAR = 9'h002,
    ST_PLACE = 9'h004,
    ST_WAIT  = 9'h008,
    ST_CALC  = 9'h010,
    ST_READ  = 9'h020,
    ST_EVAL  = 9'h040,
    ST_WRITE = 9'h080,
    ST_DONE  = 9'h100
  } state_t;

  state_t                 state_q;
  logic [TW-1:0]          tickCnt_q;
  logic [AW-1:0]          clrAddr_q;
  logic [PIW-1:0]         pIdx_q;
  logic [NUM_PLAYERS-1:0] alive_q;
  logic [NUM_PLAYERS-1:0] crashed_q;
  logic [NUM_PLAYERS-1:0] pendL_q;
  logic [NUM_PLAYERS-1:0] pendR_q;
  logic [1:0]             dir_q   [NUM_PLAYERS];
  logic [XW-1:0]          headX_q [NUM_PLAYERS];
  logic [YW-1:0]          headY_q [NUM_PLAYERS];
  logic [XW-1:0]          tgtX_q  [NUM_PLAYERS];
  logic [YW-1:0]          tgtY_q  [NUM_PLAYERS];
  logic [1:0]             winner_q;
  logic                   draw_q;

  logic [OW-1:0]          mem [CELLS];
  logic [OW-1:0]          engData_q;

  logic [1:0]             curDir;
  logic [1:0]             calcDir_d;
  logic [XW:0]            stepX_d;
  logic [YW:0]            stepY_d;
  logic                   wallHit_d;
  logic [AW-1:0]          calcAddr_d;
  logic [NUM_PLAYERS-1:0] evalCrash_d;
  logic [NUM_PLAYERS-1:0] newAlive_d;
  logic [PIW-1:0]         firstSurv_d;
  logic [PIW-1:0]         nextSurv_d;
  logic                   nextFound_d;
  logic [2:0]             aliveCnt_d;
  logic                   latchEn;
  logic [OW-1:0]          owner;
  logic                   memWe;
  logic [AW-1:0]          memWAddr;
  logic [OW-1:0]          memWData;
  logic [XW-1:0]          startX [NUM_PLAYERS];

  function automatic logic [AW-1:0] cellAddr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  function automatic logic [2:0] countSet(input logic [NUM_PLAYERS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  // Start columns spread the bikes evenly across the field
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : gStart
    assign startX[g] = XW'((g + 1) * GRID_W / (NUM_PLAYERS + 1));
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : gHead
    assign head_x[g*XW +: XW] = headX_q[g];
    assign head_y[g*YW +: YW] = headY_q[g];
  end

  assign state   = state_q;
  assign alive   = alive_q;
  assign winner  = winner_q;
  assign draw    = draw_q;
  assign owner   = OW'(pIdx_q) + OW'(1);
  assign latchEn = !(state_q inside {ST_IDLE, ST_CLEAR, ST_DONE});

  // Apply the pending turn of the current player and compute its target cell;
  // the extra coordinate bit catches stepping off either edge of the field
  always_comb begin
    curDir    = dir_q[pIdx_q];
    calcDir_d = curDir;
    if (pendL_q[pIdx_q] && !pendR_q[pIdx_q]) begin
      calcDir_d = curDir - 2'd1;
    end else if (pendR_q[pIdx_q] && !pendL_q[pIdx_q]) begin
      calcDir_d = curDir + 2'd1;
    end
    stepX_d = {1'b0, headX_q[pIdx_q]};
    stepY_d = {1'b0, headY_q[pIdx_q]};
    case (calcDir_d)
      DIR_N:   stepY_d = stepY_d - (YW + 1)'(1);
      DIR_E:   stepX_d = stepX_d + (XW + 1)'(1);
      DIR_S:   stepY_d = stepY_d + (YW + 1)'(1);
      default: stepX_d = stepX_d - (XW + 1)'(1);
    endcase
    wallHit_d  = (stepX_d >= X_LIMIT) || (stepY_d >= Y_LIMIT);
    calcAddr_d = cellAddr(stepX_d[XW-1:0], stepY_d[YW-1:0]);
  end

  // Head-on resolution: live, uncrashed bikes aiming at the same cell all die
  always_comb begin
    evalCrash_d = crashed_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      for (int j = i + 1; j < NUM_PLAYERS; j++) begin
        if (alive_q[i] && alive_q[j] && !crashed_q[i] && !crashed_q[j] &&
            (tgtX_q[i] == tgtX_q[j]) && (tgtY_q[i] == tgtY_q[j])) begin
          evalCrash_d[i] = 1'b1;
          evalCrash_d[j] = 1'b1;
        end
      end
    end
    newAlive_d = alive_q & ~evalCrash_d;
  end

  // Survivor walk for WRITE: first survivor after EVAL, next survivor after the current one
  always_comb begin
    firstSurv_d = '0;
    nextSurv_d  = '0;
    nextFound_d = 1'b0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (newAlive_d[i]) firstSurv_d = PIW'(i);
    end
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (alive_q[i] && (i > int'(pIdx_q))) begin
        nextSurv_d  = PIW'(i);
        nextFound_d = 1'b1;
      end
    end
    aliveCnt_d = countSet(alive_q);
  end

  // Engine-side write port: clear sweep, start cells and trail extension
  always_comb begin
    memWe    = 1'b0;
    memWAddr = '0;
    memWData = '0;
    if (!Reset) begin
      case (state_q)
        ST_CLEAR: begin
          memWe    = 1'b1;
          memWAddr = clrAddr_q;
        end
        ST_PLACE: begin
          memWe    = 1'b1;
          memWAddr = cellAddr(startX[pIdx_q], START_Y);
          memWData = owner;
        end
        ST_WRITE: begin
          memWe    = 1'b1;
          memWAddr = cellAddr(tgtX_q[pIdx_q], tgtY_q[pIdx_q]);
          memWData = owner;
        end
        default: ;
      endcase
    end
  end

  // Dual-port occupancy memory; both reads see the value before a same-cycle write
  always_ff @(posedge Clk) begin
    if (memWe) mem[memWAddr] <= memWData;
    if (int'(calcAddr_d) < CELLS) engData_q <= mem[calcAddr_d];
    else                          engData_q <= '0;
    if (int'(rd_addr) < CELLS) rd_data <= mem[rd_addr];
    else                       rd_data <= '0;
  end

  // Game sequencer: clear, place, then tick/calc/read/eval/write until a result
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      tickCnt_q <= '0;
      clrAddr_q <= '0;
      pIdx_q    <= '0;
      alive_q   <= '0;
      crashed_q <= '0;
      pendL_q   <= '0;
      pendR_q   <= '0;
      winner_q  <= '0;
      draw_q    <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        dir_q[p]   <= DIR_N;
        headX_q[p] <= '0;
        headY_q[p] <= '0;
        tgtX_q[p]  <= '0;
        tgtY_q[p]  <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q   <= ST_CLEAR;
            clrAddr_q <= '0;
            alive_q   <= '0;
            winner_q  <= '0;
            draw_q    <= 1'b0;
            pendL_q   <= '0;
            pendR_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (clrAddr_q == LAST_CELL) begin
            state_q <= ST_PLACE;
            pIdx_q  <= '0;
          end else begin
            clrAddr_q <= clrAddr_q + AW'(1);
          end
        end
        ST_PLACE: begin
          headX_q[pIdx_q] <= startX[pIdx_q];
          headY_q[pIdx_q] <= START_Y;
          dir_q[pIdx_q]   <= pIdx_q[0] ? DIR_S : DIR_N;
          alive_q[pIdx_q] <= 1'b1;
          if (pIdx_q == LAST_P) begin
            state_q   <= ST_WAIT;
            tickCnt_q <= '0;
          end else begin
            pIdx_q <= pIdx_q + PIW'(1);
          end
        end
        ST_WAIT: begin
          if (tickCnt_q == LAST_TICK) begin
            state_q <= ST_CALC;
            pIdx_q  <= '0;
          end else begin
            tickCnt_q <= tickCnt_q + TW'(1);
          end
        end
        ST_CALC: begin
          if (alive_q[pIdx_q]) begin
            dir_q[pIdx_q]     <= calcDir_d;
            pendL_q[pIdx_q]   <= 1'b0;
            pendR_q[pIdx_q]   <= 1'b0;
            tgtX_q[pIdx_q]    <= stepX_d[XW-1:0];
            tgtY_q[pIdx_q]    <= stepY_d[YW-1:0];
            crashed_q[pIdx_q] <= wallHit_d;
          end
          state_q <= ST_READ;
        end
        ST_READ: begin
          if (alive_q[pIdx_q] && !crashed_q[pIdx_q] && (engData_q != '0)) begin
            crashed_q[pIdx_q] <= 1'b1;
          end
          if (pIdx_q == LAST_P) begin
            state_q <= ST_EVAL;
          end else begin
            pIdx_q  <= pIdx_q + PIW'(1);
            state_q <= ST_CALC;
          end
        end
        ST_EVAL: begin
          alive_q <= newAlive_d;
          if (newAlive_d == '0) begin
            draw_q   <= 1'b1;
            winner_q <= '0;
            state_q  <= ST_DONE;
          end else begin
            pIdx_q  <= firstSurv_d;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          headX_q[pIdx_q] <= tgtX_q[pIdx_q];
          headY_q[pIdx_q] <= tgtY_q[pIdx_q];
          if (nextFound_d) begin
            pIdx_q <= nextSurv_d;
          end else if (aliveCnt_d >= 3'd2) begin
            state_q   <= ST_WAIT;
            tickCnt_q <= '0;
          end else begin
            winner_q <= 2'(pIdx_q);
            draw_q   <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (Ack) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Latched after the sequencer so a pulse in a player's CALC cycle carries to the next tick
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (latchEn && alive_q[p]) begin
          if (TurnL[p]) pendL_q[p] <= 1'b1;
          if (TurnR[p]) pendR_q[p] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lightbike_engine.sv
// tb_lightbike_engine: directed bench for lightbike_engine.
// Instance A is a 16x16 field, instance B a 12x12 field; both have 2 players.
`timescale 1ns/1ps
module tb_lightbike_engine;

  localparam logic [8:0] S_IDLE = 9'h001;
  localparam logic [8:0] S_WAIT = 9'h008;
  localparam logic [8:0] S_CALC = 9'h010;
  localparam logic [8:0] S_READ = 9'h020;
  localparam logic [8:0] S_DONE = 9'h100;

  logic       clock;
  logic       reset;
  logic       aStart;
  logic       bStart;
  logic       ack;
  logic [1:0] turnL;
  logic [1:0] turnR;
  logic [7:0] rdAddr;
  logic [1:0] aRdData, bRdData;
  logic [1:0] aAlive, bAlive;
  logic [7:0] aHeadX, aHeadY, bHeadX, bHeadY;
  logic [1:0] aWinner, bWinner;
  logic       aDraw, bDraw;
  logic [8:0] aState, bState;

  int vectors = 0;
  int miscompares = 0;

  lightbike_engine #(.GRID_W(16), .GRID_H(16), .NUM_PLAYERS(2), .TICK_CYCLES(8)) dutA (
    .Clk(clock), .Reset(reset), .Start(aStart), .Ack(ack),
    .TurnL(turnL), .TurnR(turnR), .rd_addr(rdAddr), .rd_data(aRdData),
    .alive(aAlive), .head_x(aHeadX), .head_y(aHeadY),
    .winner(aWinner), .draw(aDraw), .state(aState)
  );

  lightbike_engine #(.GRID_W(12), .GRID_H(12), .NUM_PLAYERS(2), .TICK_CYCLES(8)) dutB (
    .Clk(clock), .Reset(reset), .Start(bStart), .Ack(ack),
    .TurnL(turnL), .TurnR(turnR), .rd_addr(rdAddr), .rd_data(bRdData),
    .alive(bAlive), .head_x(bHeadX), .head_y(bHeadY),
    .winner(bWinner), .draw(bDraw), .state(bState)
  );

  // Free-running 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case a bounded wait is somehow bypassed
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of control inputs starting at a falling edge, then release them
  task automatic applyStimulus(input logic sa, input logic sb, input logic ak,
                               input logic [1:0] l, input logic [1:0] r);
    aStart = sa;
    bStart = sb;
    ack    = ak;
    turnL  = l;
    turnR  = r;
    @(negedge clock);
    aStart = 1'b0;
    bStart = 1'b0;
    ack    = 1'b0;
    turnL  = 2'b00;
    turnR  = 2'b00;
  endtask

  task automatic waitState(input bit useB, input logic [8:0] mask, input int budget, output int cycles);
    logic [8:0] cur;
    cycles = 0;
    cur = useB ? bState : aState;
    while (((cur & mask) == 9'd0) && (cycles < budget)) begin
      @(negedge clock);
      cycles++;
      cur = useB ? bState : aState;
    end
    if ((cur & mask) == 9'd0) checkOutput("waitState timeout", 32'(cur), 32'(mask));
  endtask

  // From the first WAIT cycle of a tick to the first WAIT (or DONE) cycle after it
  task automatic waitTick(input bit useB, output int cycles);
    int c1;
    int c2;
    waitState(useB, S_CALC, 100, c1);
    waitState(useB, S_WAIT | S_DONE, 100, c2);
    cycles = c1 + c2;
  endtask

  task automatic readCell(input bit useB, input int addr, output logic [1:0] data);
    rdAddr = 8'(addr);
    @(negedge clock);
    data = useB ? bRdData : aRdData;
  endtask

  initial begin
    int cyc;
    int bad;
    logic [1:0] d;
    logic [1:0] expCell;

    reset  = 1'b1;
    aStart = 1'b0;
    bStart = 1'b0;
    ack    = 1'b0;
    turnL  = 2'b00;
    turnR  = 2'b00;
    rdAddr = 8'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    checkOutput("reset state", 32'(aState), 'h001);
    checkOutput("reset alive", 32'(aAlive), 'h0);
    checkOutput("reset winner", 32'(aWinner), 'h0);
    checkOutput("reset draw", 32'(aDraw), 'h0);
    checkOutput("reset head_x", 32'(aHeadX), 'h0);
    checkOutput("reset head_y", 32'(aHeadY), 'h0);

    // Game A1: no turns, p1 runs off the bottom on tick 8
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    waitState(1'b0, S_WAIT, 400, cyc);
    checkOutput("A1 place head_x", 32'(aHeadX), 'hA5);
    checkOutput("A1 place head_y", 32'(aHeadY), 'h88);
    checkOutput("A1 place alive", 32'(aAlive), 'h3);
    waitTick(1'b0, cyc);
    checkOutput("A1 tick cycles two alive", 32'(cyc), 15);
    checkOutput("A1 tick1 head_y", 32'(aHeadY), 'h97);
    repeat (6) waitTick(1'b0, cyc);
    checkOutput("A1 tick7 head_y", 32'(aHeadY), 'hF1);
    waitTick(1'b0, cyc);
    checkOutput("A1 final tick cycles", 32'(cyc), 14);
    checkOutput("A1 done state", 32'(aState), 'h100);
    checkOutput("A1 winner", 32'(aWinner), 'h0);
    checkOutput("A1 draw", 32'(aDraw), 'h0);
    checkOutput("A1 alive", 32'(aAlive), 'h1);
    checkOutput("A1 final head_x", 32'(aHeadX), 'hA5);
    checkOutput("A1 final head_y", 32'(aHeadY), 'hF0);
    readCell(1'b0, 5, d);
    checkOutput("A1 cell (5,0)", 32'(d), 'h1);
    readCell(1'b0, 250, d);
    checkOutput("A1 cell (10,15)", 32'(d), 'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    checkOutput("A1 ack to idle", 32'(aState), 'h001);

    // Game A2: cancelled turn, then three right turns bring p0 back onto its own trail
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    waitState(1'b0, S_WAIT, 400, cyc);
    checkOutput("A2 replace head_x", 32'(aHeadX), 'hA5);
    checkOutput("A2 replace head_y", 32'(aHeadY), 'h88);
    readCell(1'b0, 5, d);
    checkOutput("A2 old trail cleared", 32'(d), 'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    waitTick(1'b0, cyc);
    checkOutput("A2 cancel head_x", 32'(aHeadX), 'hA5);
    checkOutput("A2 cancel head_y", 32'(aHeadY), 'h97);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    waitTick(1'b0, cyc);
    checkOutput("A2 tick2 head_x", 32'(aHeadX), 'hA6);
    checkOutput("A2 tick2 head_y", 32'(aHeadY), 'hA7);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    waitTick(1'b0, cyc);
    checkOutput("A2 tick3 head_x", 32'(aHeadX), 'hA6);
    checkOutput("A2 tick3 head_y", 32'(aHeadY), 'hB8);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    waitTick(1'b0, cyc);
    checkOutput("A2 done state", 32'(aState), 'h100);
    checkOutput("A2 winner", 32'(aWinner), 'h1);
    checkOutput("A2 draw", 32'(aDraw), 'h0);
    checkOutput("A2 alive", 32'(aAlive), 'h2);
    checkOutput("A2 frozen head_x", 32'(aHeadX), 'hA6);
    checkOutput("A2 frozen head_y", 32'(aHeadY), 'hC8);
    readCell(1'b0, 133, d);
    checkOutput("A2 crash cell (5,8)", 32'(d), 'h1);
    readCell(1'b0, 134, d);
    checkOutput("A2 cell (6,8)", 32'(d), 'h1);
    readCell(1'b0, 202, d);
    checkOutput("A2 cell (10,12)", 32'(d), 'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    checkOutput("A2 ack to idle", 32'(aState), 'h001);
    checkOutput("A2 winner held", 32'(aWinner), 'h1);
    checkOutput("A2 draw held", 32'(aDraw), 'h0);

    // Game A3: reset in the READ of tick 3, then a full game and a memory sweep
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    waitState(1'b0, S_WAIT, 400, cyc);
    waitTick(1'b0, cyc);
    waitTick(1'b0, cyc);
    waitState(1'b0, S_READ, 50, cyc);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("A3 mid-game reset state", 32'(aState), 'h001);
    checkOutput("A3 mid-game reset alive", 32'(aAlive), 'h0);
    checkOutput("A3 mid-game reset head_x", 32'(aHeadX), 'h0);
    checkOutput("A3 mid-game reset head_y", 32'(aHeadY), 'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    waitState(1'b0, S_WAIT, 400, cyc);
    readCell(1'b0, 134, d);
    checkOutput("A3 stale trail cleared", 32'(d), 'h0);
    readCell(1'b0, 133, d);
    checkOutput("A3 start cell p0", 32'(d), 'h1);
    readCell(1'b0, 138, d);
    checkOutput("A3 start cell p1", 32'(d), 'h2);
    repeat (8) waitTick(1'b0, cyc);
    checkOutput("A3 done state", 32'(aState), 'h100);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      int x;
      int y;
      x = a % 16;
      y = a / 16;
      if (x == 5 && y <= 8)       expCell = 2'd1;
      else if (x == 10 && y >= 8) expCell = 2'd2;
      else                        expCell = 2'd0;
      readCell(1'b0, a, d);
      if (d !== expCell) bad++;
    end
    checkOutput("A3 memory sweep bad cells", 32'(bad), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);

    // Game B: 12x12 head-on collision
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    waitState(1'b1, S_WAIT, 300, cyc);
    checkOutput("B place head_x", 32'(bHeadX), 'h84);
    checkOutput("B place head_y", 32'(bHeadY), 'h66);
    checkOutput("B place alive", 32'(bAlive), 'h3);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    waitTick(1'b1, cyc);
    checkOutput("B tick1 head_x", 32'(bHeadX), 'h75);
    checkOutput("B tick1 head_y", 32'(bHeadY), 'h66);
    waitTick(1'b1, cyc);
    checkOutput("B final tick cycles", 32'(cyc), 13);
    checkOutput("B done state", 32'(bState), 'h100);
    checkOutput("B draw", 32'(bDraw), 'h1);
    checkOutput("B alive", 32'(bAlive), 'h0);
    checkOutput("B frozen head_x", 32'(bHeadX), 'h75);
    readCell(1'b1, 78, d);
    checkOutput("B meet cell unwritten", 32'(d), 'h0);
    readCell(1'b1, 77, d);
    checkOutput("B cell (5,6)", 32'(d), 'h1);
    readCell(1'b1, 79, d);
    checkOutput("B cell (7,6)", 32'(d), 'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    checkOutput("B ack to idle", 32'(bState), 'h001);
    checkOutput("B draw held", 32'(bDraw), 'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
